r7_uart_monitor: RTL
====================

Name: r7_uart_monitor

Overview:
- Downstream observer of the CPU core.
- Watches the core's r7 result register and program counter; every time r7 changes value, captures a {PC, r7} snapshot into a small FIFO.
- Serializes each snapshot as a 3-byte UART frame (8N1, LSB first) on one TX pin, so results can be checked on a host without a logic analyser.
- Sits beside the core at board top level; no feedback into the core.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal >= 2.
- DEPTH, 8, FIFO entries; power of 2, legal 2..64.

Ports:
- clock  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- r7_data  in  16  core r7 register value.
- pc_in  in  5  core PC_out value.
- tx  out  1  UART serial line, idle high.
- busy  out  1  high while a frame is being transmitted.
- overflow  out  1  sticky: a snapshot was dropped because the FIFO was full.
- fifo_count  out  $clog2(DEPTH)+1  entries currently held.

Behaviour:
- Reset values: tx=1, busy=0, overflow=0, fifo_count=0, r7_prev=16'h0000, FSM=IDLE, FIFO pointers 0. Reset mid-frame aborts the frame; tx is high from the next edge and FIFO contents are discarded.
- Change detect:
  - At each edge, if r7_data != r7_prev, push {pc_in, r7_data} (21 bits) and update r7_prev.
  - r7_prev updates even when the push is dropped.
  - r7 staying at 0 after reset produces no snapshot.
- FIFO:
  - Circular buffer, pointers wrap modulo DEPTH.
  - Push when full: entry dropped, overflow set to 1 and held until reset.
  - Push and pop in the same cycle while full: both succeed; count unchanged; no overflow.
  - Pop when empty never occurs.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if fifo_count != 0, pop the head entry into a 21-bit hold register, set byte_idx=0, load the shift register with byte0 -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte_idx<2: increment byte_idx, load the next byte -> START. Else -> IDLE.
  - Byte order: byte0={3'b000, pc[4:0]}, byte1=r7[15:8], byte2=r7[7:0].
  - busy=1 in every state except IDLE.
  - Frame length is 30*CLKS_PER_BIT cycles (33 with parity). Back-to-back frames have no idle gap beyond the IDLE decision cycle.
- Latency: a change sampled at edge E0 is pushed at E0. The FSM pops at E1, with tx=0 and busy=1 from E1. Frame start is therefore 1 cycle after capture when the FSM is idle.
- Bit timer: counts 0..CLKS_PER_BIT-1 and resets on every state transition.
- Arithmetic: fifo_count is the registered count, +1 on push only, -1 on pop only.

Optional Feature:
- Macro: R7_MON_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles. Frames are 11 bits per byte.
- Undefined: the PARITY state and its logic are absent; 8N1 framing.

Decomposition:
- Shared package r7_mon_pkg holds:
  - the FSM state encoding (2-bit, 3-bit with parity);
  - the BYTES_PER_FRAME=3 constant;
  - the entry-width constant ENTRY_W=21.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count). It is reused later by other board-level monitors.
- The UART serializer stays inline.

Test Plan (CLKS_PER_BIT=4, DEPTH=4):
1. Reset, hold r7_data=0 for 200 cycles -> tx stays 1, busy=0, fifo_count=0.
2. r7_data 0->16'h12AB with pc_in=5'd7 -> tx low 1 cycle later. Decoded bytes are 0x07, 0x12, 0xAB. busy falls after 120 cycles.
3. Change r7 on 6 consecutive cycles (values 1..6, pc 0..5) while the FSM is idle:
   - value 1 is popped immediately;
   - values 2..5 fill the FIFO; value 6 is dropped and overflow=1;
   - output frames carry r7 = 1, 2, 3, 4, 5.
4. Push on the exact cycle the FSM pops while the FIFO is full -> count stays at DEPTH and overflow stays 0.
5. Assert reset mid-DATA of byte1 -> next edge tx=1, busy=0, fifo_count=0, overflow=0. No further bits are sent.
6. With R7_MON_PARITY_EN, send r7=16'h0103, pc=1 -> parity bits are 1, 1, 0 for bytes 0x01, 0x01, 0x03. Frame length is 132 cycles.

Source files
------------

// File: rtl/r7_mon_pkg.sv
// ---------------------------------------------------------------------------
// r7_mon_pkg
// Shared definitions for the r7 UART monitor: snapshot entry width, bytes per
// UART frame, the serializer state encoding and the frame byte selector.
// Optional build macro: R7_MON_PARITY_EN (adds the PARITY state).
// ---------------------------------------------------------------------------
package r7_mon_pkg;

    localparam int unsigned ENTRY_W         = 21;
    localparam int unsigned BYTES_PER_FRAME = 3;

`ifdef R7_MON_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        IDLE, START, DATA, STOP
    } tx_state_t;
`endif

    // Snapshot layout is {pc[4:0], r7[15:0]}; frame order is pc, r7 high, r7 low.
    function automatic logic [7:0] frame_byte(input logic [ENTRY_W-1:0] entry,
                                              input logic [1:0]         idx);
        case (idx)
            2'd0:    frame_byte = {3'b000, entry[20:16]};
            2'd1:    frame_byte = entry[15:8];
            default: frame_byte = entry[7:0];
        endcase
    endfunction

endpackage

// File: rtl/r7_uart_monitor_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock circular-buffer FIFO with show-ahead read data.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   i_push, i_din     write request / data (dropped when full unless popping)
//   i_pop             read request (caller never pops when empty)
//   o_dout            head entry
//   o_full, o_empty   status flags
//   o_count           entries held, 0..DEPTH
// DEPTH must be a power of 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];

    // A simultaneous pop frees the slot, so a push into a full FIFO succeeds.
    assign w_push_ok = i_push && (!o_full || i_pop);
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/r7_uart_monitor.sv
// ---------------------------------------------------------------------------
// r7_uart_monitor
// Observes the core's r7 register; on every value change a {pc, r7} snapshot
// is queued and later sent as a 3-byte UART frame (LSB first, idle high).
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   r7_data        core r7 value
//   pc_in          core PC
//   tx             UART line
//   busy           frame in progress
//   overflow       sticky: a snapshot was dropped on a full FIFO
//   fifo_count     snapshots queued
// Build macro R7_MON_PARITY_EN adds an even-parity bit per byte (8E1).
// ---------------------------------------------------------------------------
module r7_uart_monitor
    import r7_mon_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [15:0]            r7_data,
    input  logic [4:0]             pc_in,
    output logic                   tx,
    output logic                   busy,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]    BYTE_LAST = 2'(BYTES_PER_FRAME - 1);

    tx_state_t          r_state;
    logic [15:0]        r_r7_prev;
    logic               r_overflow;
    logic               r_tx;
    logic               r_busy;
    logic [TW-1:0]      r_timer;
    logic [2:0]         r_bit_idx;
    logic [1:0]         r_byte_idx;
    logic [7:0]         r_shift;
    logic [ENTRY_W-1:0] r_hold;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_head;
    logic               w_bit_end;

    assign w_push    = (r7_data != r_r7_prev);
    assign w_pop     = (r_state == IDLE) && !w_empty;
    assign w_bit_end = (r_timer == BIT_LAST);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   ({pc_in, r7_data}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // r7_prev tracks every change, including ones whose push is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_r7_prev  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_r7_prev <= r7_data;
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // The shift register rotates rather than shifts so that after the 8 data
    // bits it holds the original byte again; ^r_shift is its parity throughout.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_hold     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_hold     <= w_head;
                        r_byte_idx <= 2'd0;
                        r_shift    <= frame_byte(w_head, 2'd0);
                        r_timer    <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        r_shift <= {r_shift[0], r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
`ifdef R7_MON_PARITY_EN
                            r_tx    <= ^r_shift;
                            r_state <= PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
`ifdef R7_MON_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (r_byte_idx != BYTE_LAST) begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_shift    <= frame_byte(r_hold, r_byte_idx + 2'd1);
                            r_tx       <= 1'b0;
                            r_state    <= START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_timer <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign overflow = r_overflow;

endmodule
